mem_sched: RTL and testbench

// Round-robin scheduler that shares the single 8-bit memory port between CLIENT_CNT requesters
// (fetch, exec, ...). Serialises 8/16/32-bit client accesses into little-endian byte cycles.

---
 rtl/mem_sched.sv | 149 ++++++++++++++
 tb/tb_mem_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sched.sv
// Round-robin scheduler sharing one 8-bit memory port between CLIENT_CNT requesters.
// Serialises 8/16/32-bit client accesses into little-endian byte cycles, one ready pulse per access.
module mem_sched #(
  parameter int A_WIDTH    = 8,
  parameter int CLIENT_CNT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENT_CNT-1:0]         requests,
  input  logic [CLIENT_CNT*A_WIDTH-1:0] client_addrs,
  input  logic [CLIENT_CNT-1:0]         client_wes,
  input  logic [2*CLIENT_CNT-1:0]       client_widths,
  input  logic [32*CLIENT_CNT-1:0]      client_wdata,
  output logic [CLIENT_CNT-1:0]         client_readies,
  output logic [31:0]                   rdata,
  output logic [A_WIDTH-1:0]            mem_addr,
  output logic [7:0]                    mem_wdata,
  output logic                          mem_we,
  input  logic [7:0]                    mem_rdata
);

  localparam int PW = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t                state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         pick;
  logic [A_WIDTH-1:0]    base;
  logic                  lat_we;
  logic [31:0]           lat_wdata;
  logic [1:0]            idx;
  logic [1:0]            last_idx;
  logic [A_WIDTH-1:0]    sel_addr;
  logic                  sel_we;
  logic [1:0]            sel_width;
  logic [31:0]           sel_wdata;
  logic [CLIENT_CNT-1:0] grant_onehot;

  // Scanned from the far end so the candidate closest to ptr is the last one kept.
  function automatic logic [PW-1:0] rr_pick(input logic [CLIENT_CNT-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic [CLIENT_CNT-1:0] rot;
    int unsigned           c;
    rr_pick = ptr;
    for (int unsigned i = CLIENT_CNT; i > 0; i--) begin
      c   = (32'(ptr) + i - 1) % CLIENT_CNT;
      rot = req >> c;
      if (rot[0]) rr_pick = PW'(c);
    end
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    int unsigned c;
    c = (32'(g) + 1) % CLIENT_CNT;
    return PW'(c);
  endfunction

  function automatic logic [1:0] width_last(input logic [1:0] w);
    case (w)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    pick      = rr_pick(requests, rr_ptr);
    sel_addr  = client_addrs[pick*A_WIDTH +: A_WIDTH];
    sel_we    = client_wes[pick];
    sel_width = client_widths[2*pick +: 2];
    sel_wdata = client_wdata[32*pick +: 32];
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      base           <= '0;
      lat_we         <= 1'b0;
      lat_wdata      <= '0;
      idx            <= '0;
      last_idx       <= '0;
      client_readies <= '0;
      rdata          <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          client_readies <= '0;
          mem_we         <= 1'b0;
          mem_wdata      <= '0;
          if (|requests) begin
            grant     <= pick;
            rr_ptr    <= rr_next(pick);
            base      <= sel_addr;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            last_idx  <= width_last(sel_width);
            idx       <= '0;
            rdata     <= '0;
            mem_addr  <= sel_addr;
            mem_we    <= sel_we;
            mem_wdata <= sel_we ? sel_wdata[7:0] : 8'h00;
            state     <= XFER;
          end
        end
        XFER: begin
          // Read data trails its address by one cycle, so this edge captures byte idx-1.
          if (!lat_we && idx != 2'd0)
            rdata[8*(idx - 2'd1) +: 8] <= mem_rdata;
          if (idx == last_idx) begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if (lat_we) begin
              client_readies <= grant_onehot;
              state          <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            idx       <= idx + 2'd1;
            mem_addr  <= base + A_WIDTH'(idx + 2'd1);
            mem_wdata <= lat_we ? lat_wdata[8*(idx + 2'd1) +: 8] : 8'h00;
          end
        end
        DRAIN: begin
          rdata[8*last_idx +: 8] <= mem_rdata;
          client_readies         <= grant_onehot;
          state                  <= DONE;
        end
        DONE: begin
          client_readies <= '0;
          mem_we         <= 1'b0;
          mem_wdata      <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: transaction-level model predicts every bus cycle and ready pulse,
// a negedge process compares, and directed tests pin key values by hand.
module tb_mem_sched;
  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  requests;
  logic [15:0] client_addrs;
  logic [1:0]  client_wes;
  logic [3:0]  client_widths;
  logic [63:0] client_wdata;
  logic [1:0]  client_readies;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int free_at = 0;
  int rr_m = 0;
  int first_wait;
  int got_c[8];
  logic [31:0] got_rd[8];

  bit [7:0]  mem[256];
  bit        ev[8192];
  bit        ewe[8192];
  bit [7:0]  ea[8192];
  bit [7:0]  ewd[8192];
  bit [1:0]  erdy[8192];
  bit [31:0] erd[8192];
  logic [7:0] cap_addr = 8'h00;
  logic [7:0] cap_wdata = 8'h00;
  logic       cap_we = 1'b0;

  mem_sched #(.A_WIDTH(8), .CLIENT_CNT(NC)) dut (
    .clk(clk), .rst(rst), .requests(requests), .client_addrs(client_addrs),
    .client_wes(client_wes), .client_widths(client_widths), .client_wdata(client_wdata),
    .client_readies(client_readies), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-transaction prediction made at the grant edge.
  task automatic predict();
    int g, n, r, idx;
    logic [7:0] base;
    bit we;
    logic [31:0] wd, rv;
    g = -1;
    for (int off = 0; off < NC; off++) begin
      idx = (rr_m + off) % NC;
      if (g < 0 && requests[idx]) g = idx;
    end
    base = client_addrs[g*8 +: 8];
    we   = client_wes[g];
    wd   = client_wdata[g*32 +: 32];
    case (client_widths[g*2 +: 2])
      2'b00:   n = 1;
      2'b01:   n = 2;
      default: n = 4;
    endcase
    rv = 32'h0;
    for (int k = 0; k < n; k++) begin
      ev[cyc+k]  = 1'b1;
      ewe[cyc+k] = we;
      ea[cyc+k]  = base + 8'(k);
      ewd[cyc+k] = wd[8*k +: 8];
      rv = rv | (32'(mem[base + 8'(k)]) << (8*k));
    end
    r = cyc + n + (we ? 0 : 1);
    erdy[r] = 2'(1 << g);
    erd[r]  = we ? 32'h0 : rv;
    free_at = r + 2;
    rr_m    = (g + 1) % NC;
  endtask

  task automatic flush();
    for (int c = cyc; c < cyc + 16; c++) begin
      ev[c]   = 1'b0;
      erdy[c] = 2'b00;
    end
  endtask

  // Memory and scheduler model.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (cap_we) mem[cap_addr] = cap_wdata;
    if (!rst) begin
      free_at = cyc + 1;
      rr_m    = 0;
    end else if (cyc >= free_at && requests != 2'b00 && cyc < 8000) begin
      predict();
    end
    #1 mem_rdata = mem[cap_addr];
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    cap_addr  = mem_addr;
    cap_we    = mem_we;
    cap_wdata = mem_wdata;
    chk("ready", client_readies, erdy[cyc]);
    chk("mem_we", mem_we, ev[cyc] && ewe[cyc]);
    if (ev[cyc]) chk("mem_addr", mem_addr, ea[cyc]);
    if (!ev[cyc] || ewe[cyc]) chk("mem_wdata", mem_wdata, ev[cyc] ? ewd[cyc] : 8'h00);
    if (erdy[cyc] != 2'b00) chk("rdata", rdata, erd[cyc]);
  end

  task automatic raise(input int c, input bit we, input logic [1:0] w,
                       input logic [7:0] a, input logic [31:0] d);
    client_addrs[c*8 +: 8]   = a;
    client_wes[c]            = we;
    client_widths[c*2 +: 2]  = w;
    client_wdata[c*32 +: 32] = d;
    requests[c]              = 1'b1;
  endtask

  // Waits for n ready pulses; drop_each releases each client at the edge after its ready.
  task automatic collect(input int n, input bit drop_each);
    int got;
    logic [1:0] dm;
    got = 0;
    dm = 2'b00;
    first_wait = -1;
    for (int k = 0; k < 300 && got < n; k++) begin
      @(posedge clk);
      #1;
      if (dm != 2'b00) begin
        requests = requests & ~dm;
        dm = 2'b00;
      end
      if (client_readies != 2'b00) begin
        if (got == 0) first_wait = k + 1;
        got_c[got]  = client_readies[1] ? 1 : 0;
        got_rd[got] = rdata;
        got++;
        if (drop_each) dm = client_readies;
      end
    end
    chk("ready_count", got, n);
    @(posedge clk);
    #1;
    requests = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    requests = '0;
    client_addrs = '0;
    client_wes = '0;
    client_widths = '0;
    client_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_readies", client_readies, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b1;

    // 8-bit write by client 0
    raise(0, 1'b1, 2'b00, 8'h10, 32'h0000_00A5);
    collect(1, 1'b1);
    chk("t1_wait", first_wait, 2);
    chk("t1_client", got_c[0], 0);
    chk("t1_mem", mem[8'h10], 8'hA5);

    // 32-bit read by client 1 wrapping past 0xFF
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    raise(1, 1'b0, 2'b10, 8'hFE, 32'h0);
    collect(1, 1'b1);
    chk("t2_wait", first_wait, 6);
    chk("t2_client", got_c[0], 1);
    chk("t2_rdata", got_rd[0], 32'h4433_2211);

    // 16-bit read, upper bytes must be zero
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'hAB; mem[8'h22] = 8'hEE; mem[8'h23] = 8'hFF;
    raise(0, 1'b0, 2'b01, 8'h20, 32'h0);
    collect(1, 1'b1);
    chk("t3_wait", first_wait, 4);
    chk("t3_rdata", got_rd[0], 32'h0000_ABCD);

    // Continuous contention after reset: strict alternation starting at client 0
    @(posedge clk);
    #3 rst = 1'b0;
    flush();
    @(posedge clk);
    #1 rst = 1'b1;
    mem[8'h60] = 8'h66;
    raise(0, 1'b1, 2'b00, 8'h50, 32'h0000_005A);
    raise(1, 1'b0, 2'b00, 8'h60, 32'h0);
    collect(6, 1'b0);
    for (int k = 0; k < 6; k++) chk("t4_order", got_c[k], k % 2);
    chk("t4_rdata", got_rd[1], 32'h0000_0066);

    // Reset during byte 1 of a 32-bit write
    raise(1, 1'b1, 2'b10, 8'h70, 32'h0102_0304);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    flush();
    #1;
    chk("t5_we_drop", mem_we, 0);
    chk("t5_no_ready", client_readies, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_byte0", mem[8'h70], 8'h04);
    chk("t5_byte1", mem[8'h71], 8'h00);
    raise(0, 1'b0, 2'b00, 8'h70, 32'h0);
    rst = 1'b1;
    collect(2, 1'b1);
    chk("t5_first", got_c[0], 0);
    chk("t5_rdata", got_rd[0], 32'h0000_0004);
    chk("t5_second", got_c[1], 1);
    chk("t5_redo", mem[8'h73], 8'h01);

    // Fields changed after grant must not matter
    raise(1, 1'b1, 2'b01, 8'h40, 32'h0000_BEEF);
    @(posedge clk);
    #2;
    client_wdata[32 +: 32] = 32'h0000_1234;
    client_addrs[8 +: 8]   = 8'h99;
    client_widths[3:2]     = 2'b00;
    collect(1, 1'b1);
    chk("t6_wait", first_wait, 2);
    chk("t6_lo", mem[8'h40], 8'hEF);
    chk("t6_hi", mem[8'h41], 8'hBE);
    chk("t6_stray", mem[8'h99], 8'h00);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
